// File: rtl/msg_event_coordinator_if.sv
// Event-pulse and log-stream bundle between the event sources / log reader and msg_event_coordinator.
// The slave modport is the coordinator's side of the bundle.
interface msg_event_coordinator_if #(
  parameter int N_SRC = 8,
  parameter int SRC_W = $clog2(N_SRC)
);
  logic [N_SRC-1:0] ev_fatal;
  logic [N_SRC-1:0] ev_error;
  logic [N_SRC-1:0] ev_warn;
  logic [N_SRC-1:0] ev_info;
  logic [N_SRC-1:0] ev_debug;
  logic             log_valid;
  logic             log_ready;
  logic [2:0]       log_sev;
  logic [SRC_W-1:0] log_src;

  modport master (
    output ev_fatal, ev_error, ev_warn, ev_info, ev_debug, log_ready,
    input  log_valid, log_sev, log_src
  );

  modport slave (
    input  ev_fatal, ev_error, ev_warn, ev_info, ev_debug, log_ready,
    output log_valid, log_sev, log_src
  );
endinterface

// File: rtl/msg_event_coordinator.sv
// On-chip health monitor: severity counters, sticky flags, error-limit/timeout stop request
// and a small log FIFO carrying one arbitrated event per cycle.
//
//  state   | meaning
//  ST_RUN  | counting events, timer running, logging
//  ST_STOP | stop requested; counters/timer frozen, log FIFO still drains
module msg_event_coordinator #(
  parameter int N_SRC     = 8,
  parameter int CNT_W     = 16,
  parameter int TO_W      = 32,
  parameter int LOG_DEPTH = 4,
  parameter int SRC_W     = $clog2(N_SRC)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic [CNT_W-1:0]     i_cfg_error_limit,
  input  logic [TO_W-1:0]      i_cfg_timeout,
  input  logic                 i_cfg_warn_en,
  input  logic                 i_cfg_info_en,
  input  logic                 i_cfg_debug_en,
  msg_event_coordinator_if.slave bus,
  output logic [CNT_W-1:0]     o_error_count,
  output logic [CNT_W-1:0]     o_warn_count,
  output logic [CNT_W-1:0]     o_log_drop_count,
  output logic                 o_error_flag,
  output logic                 o_fatal_flag,
  output logic                 o_timeout_flag,
  output logic                 o_stop_req,
  output logic [1:0]           o_stop_cause,
  output logic                 o_first_err_valid,
  output logic [SRC_W-1:0]     o_first_err_src
);
  localparam int INC_W = SRC_W + 3;
  localparam int SUM_W = CNT_W + INC_W + 1;
  localparam int AW    = $clog2(LOG_DEPTH);
  localparam int ENT_W = 3 + SRC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_RUN, ST_STOP} state_t;

  function automatic logic [INC_W-1:0] f_popcnt(input logic [N_SRC-1:0] v);
    logic [INC_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_SRC; i++) n = n + INC_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  function automatic logic [SRC_W-1:0] f_lowest(input logic [N_SRC-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (v[i]) idx = SRC_W'(i);
    return idx;
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_error_count, r_warn_count, r_drop_count;
  logic               r_error_flag, r_fatal_flag, r_timeout_flag, r_stop_req;
  logic [1:0]         r_stop_cause;
  logic               r_first_err_valid;
  logic [SRC_W-1:0]   r_first_err_src;
  logic [TO_W-1:0]    r_timer;
  logic [ENT_W-1:0]   r_mem [LOG_DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_log_valid;
  logic [2:0]         r_log_sev;
  logic [SRC_W-1:0]   r_log_src;

  logic               w_run, w_to_hit, w_limit_hit, w_any_err, w_any_fatal;
  logic [INC_W-1:0]   w_err_inc, w_elig_cnt;
  logic [CNT_W-1:0]   w_err_next, w_warn_next, w_drop_next;
  logic [N_SRC-1:0]   w_m_warn, w_m_info, w_m_debug;
  logic [2:0]         w_sel_sev;
  logic [SRC_W-1:0]   w_sel_src;
  logic               w_pop, w_full, w_push;
  logic [AW:0]        w_count_next;
  logic [AW-1:0]      w_rd_next;
  logic [ENT_W-1:0]   w_entry, w_head_next;

  always_comb begin
    w_run       = (r_state == ST_RUN);
    w_to_hit    = (i_cfg_timeout != '0) && (r_timer == i_cfg_timeout - TO_W'(1));
    w_any_fatal = |bus.ev_fatal;
    w_any_err   = |(bus.ev_fatal | bus.ev_error);
    w_err_inc   = f_popcnt(bus.ev_fatal) + f_popcnt(bus.ev_error) + INC_W'(w_to_hit);
    w_err_next  = f_sat_add(r_error_count, w_err_inc);
    w_warn_next = f_sat_add(r_warn_count, f_popcnt(bus.ev_warn));
    w_limit_hit = (i_cfg_error_limit != '0) && (w_err_next >= i_cfg_error_limit);

    w_m_warn   = i_cfg_warn_en  ? bus.ev_warn  : '0;
    w_m_info   = i_cfg_info_en  ? bus.ev_info  : '0;
    w_m_debug  = i_cfg_debug_en ? bus.ev_debug : '0;
    w_elig_cnt = f_popcnt(bus.ev_fatal) + f_popcnt(bus.ev_error) + f_popcnt(w_m_warn)
               + f_popcnt(w_m_info) + f_popcnt(w_m_debug);

    w_sel_sev = 3'd0;
    w_sel_src = '0;
    if (|bus.ev_fatal) begin
      w_sel_sev = 3'd0; w_sel_src = f_lowest(bus.ev_fatal);
    end else if (|bus.ev_error) begin
      w_sel_sev = 3'd1; w_sel_src = f_lowest(bus.ev_error);
    end else if (|w_m_warn) begin
      w_sel_sev = 3'd2; w_sel_src = f_lowest(w_m_warn);
    end else if (|w_m_info) begin
      w_sel_sev = 3'd3; w_sel_src = f_lowest(w_m_info);
    end else if (|w_m_debug) begin
      w_sel_sev = 3'd4; w_sel_src = f_lowest(w_m_debug);
    end

    w_pop        = r_log_valid && bus.log_ready;
    w_full       = (r_count == (AW+1)'(LOG_DEPTH));
    w_push       = w_run && (w_elig_cnt != '0) && (!w_full || w_pop);
    w_drop_next  = f_sat_add(r_drop_count, w_elig_cnt - INC_W'(w_push));
    w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_rd_next    = r_rd_ptr + AW'(w_pop);
    w_entry      = {w_sel_sev, w_sel_src};
    // The output head is registered; when the FIFO is empty after a pop, the new entry becomes the head.
    w_head_next  = ((r_count - (AW+1)'(w_pop)) == '0) ? w_entry : r_mem[w_rd_next];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clr && w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_state           <= ST_RUN;
      r_error_count     <= '0;
      r_warn_count      <= '0;
      r_drop_count      <= '0;
      r_error_flag      <= 1'b0;
      r_fatal_flag      <= 1'b0;
      r_timeout_flag    <= 1'b0;
      r_stop_req        <= 1'b0;
      r_stop_cause      <= 2'd0;
      r_first_err_valid <= 1'b0;
      r_first_err_src   <= '0;
      r_timer           <= '0;
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_log_valid       <= 1'b0;
      r_log_sev         <= 3'd0;
      r_log_src         <= '0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + AW'(w_push);
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_log_valid <= (w_count_next != '0);
      r_log_sev   <= w_head_next[ENT_W-1 -: 3];
      r_log_src   <= w_head_next[SRC_W-1:0];
      case (r_state)
        ST_RUN: begin
          r_error_count <= w_err_next;
          r_warn_count  <= w_warn_next;
          r_drop_count  <= w_drop_next;
          r_timer       <= r_timer + TO_W'(1);
          if (w_any_err) r_error_flag <= 1'b1;
          if (w_any_fatal || w_to_hit) r_fatal_flag <= 1'b1;
          if (w_to_hit) r_timeout_flag <= 1'b1;
          if (w_any_err && !r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_src   <= f_lowest(bus.ev_fatal | bus.ev_error);
          end
          if (w_any_fatal || w_limit_hit || w_to_hit) begin
            r_state      <= ST_STOP;
            r_stop_req   <= 1'b1;
            r_stop_cause <= w_any_fatal ? 2'd1 : (w_limit_hit ? 2'd2 : 2'd3);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_error_count     = r_error_count;
  assign o_warn_count      = r_warn_count;
  assign o_log_drop_count  = r_drop_count;
  assign o_error_flag      = r_error_flag;
  assign o_fatal_flag      = r_fatal_flag;
  assign o_timeout_flag    = r_timeout_flag;
  assign o_stop_req        = r_stop_req;
  assign o_stop_cause      = r_stop_cause;
  assign o_first_err_valid = r_first_err_valid;
  assign o_first_err_src   = r_first_err_src;
  assign bus.log_valid     = r_log_valid;
  assign bus.log_sev       = r_log_sev;
  assign bus.log_src       = r_log_src;
endmodule

// File: tb/tb_msg_event_coordinator.sv
// Directed bench for msg_event_coordinator with narrow counters so saturation is reachable.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_msg_event_coordinator;
  localparam int N_SRC     = 8;
  localparam int CNT_W     = 4;
  localparam int TO_W      = 32;
  localparam int LOG_DEPTH = 4;
  localparam int SRC_W     = 3;

  logic             clk = 1'b0;
  logic             rst_n, clr;
  logic [CNT_W-1:0] cfg_error_limit;
  logic [TO_W-1:0]  cfg_timeout;
  logic             cfg_warn_en, cfg_info_en, cfg_debug_en;
  logic [CNT_W-1:0] error_count, warn_count, log_drop_count;
  logic             error_flag, fatal_flag, timeout_flag, stop_req;
  logic [1:0]       stop_cause;
  logic             first_err_valid;
  logic [SRC_W-1:0] first_err_src;

  int n_checks = 0;
  int n_fail   = 0;

  msg_event_coordinator_if #(.N_SRC(N_SRC), .SRC_W(SRC_W)) bus ();

  msg_event_coordinator #(
    .N_SRC(N_SRC), .CNT_W(CNT_W), .TO_W(TO_W), .LOG_DEPTH(LOG_DEPTH), .SRC_W(SRC_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
    .i_cfg_error_limit(cfg_error_limit), .i_cfg_timeout(cfg_timeout),
    .i_cfg_warn_en(cfg_warn_en), .i_cfg_info_en(cfg_info_en), .i_cfg_debug_en(cfg_debug_en),
    .bus(bus),
    .o_error_count(error_count), .o_warn_count(warn_count), .o_log_drop_count(log_drop_count),
    .o_error_flag(error_flag), .o_fatal_flag(fatal_flag), .o_timeout_flag(timeout_flag),
    .o_stop_req(stop_req), .o_stop_cause(stop_cause),
    .o_first_err_valid(first_err_valid), .o_first_err_src(first_err_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.ev_fatal = '0; bus.ev_error = '0; bus.ev_warn = '0;
    bus.ev_info  = '0; bus.ev_debug = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1; idle();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int exp_src [3] = '{2, 3, 6};
    rst_n = 1'b0; clr = 1'b0;
    cfg_error_limit = '0; cfg_timeout = '0;
    cfg_warn_en = 1'b0; cfg_info_en = 1'b0; cfg_debug_en = 1'b0;
    bus.log_ready = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_err_cnt", error_count, 0);
    chk("rst_warn_cnt", warn_count, 0);
    chk("rst_drop", log_drop_count, 0);
    chk("rst_stop", stop_req, 0);
    chk("rst_cause", stop_cause, 0);
    chk("rst_log_valid", bus.log_valid, 0);
    chk("rst_first_valid", first_err_valid, 0);

    // Timeout: 100 RUN cycles after reset release
    cfg_timeout = 100;
    rst_n = 1'b1;
    repeat (99) @(negedge clk);
    chk("to_early", stop_req, 0);
    @(negedge clk);
    chk("to_stop", stop_req, 1);
    chk("to_cause", stop_cause, 3);
    chk("to_err_cnt", error_count, 1);
    chk("to_flag", timeout_flag, 1);
    chk("to_fatal_flag", fatal_flag, 1);
    chk("to_error_flag", error_flag, 0);
    cfg_timeout = '0;
    do_clr();
    chk("clr_stop", stop_req, 0);
    chk("clr_cause", stop_cause, 0);
    chk("clr_err_cnt", error_count, 0);
    chk("clr_to_flag", timeout_flag, 0);

    // Error limit 3
    cfg_error_limit = 3; bus.log_ready = 1'b1;
    bus.ev_error = 8'h01; @(negedge clk);
    chk("lim_cnt1", error_count, 1);
    chk("lim_stop1", stop_req, 0);
    chk("lim_first_valid", first_err_valid, 1);
    bus.ev_error = 8'h06; @(negedge clk); idle();
    chk("lim_cnt3", error_count, 3);
    chk("lim_stop", stop_req, 1);
    chk("lim_cause", stop_cause, 2);
    chk("lim_first_src", first_err_src, 0);
    chk("lim_drop", log_drop_count, 1);

    // clr wins over same-cycle events
    clr = 1'b1; bus.ev_error = 8'hFF; bus.ev_fatal = 8'h01;
    @(negedge clk); clr = 1'b0; idle();
    chk("clrprio_cnt", error_count, 0);
    chk("clrprio_fatal", fatal_flag, 0);
    chk("clrprio_stop", stop_req, 0);
    chk("clrprio_log", bus.log_valid, 0);

    // Fatal beats limit
    cfg_error_limit = 1; bus.log_ready = 1'b0;
    bus.ev_fatal = 8'h10; bus.ev_error = 8'h02; @(negedge clk); idle();
    chk("fat_cause", stop_cause, 1);
    chk("fat_cnt", error_count, 2);
    chk("fat_first_src", first_err_src, 1);
    chk("fat_flag", fatal_flag, 1);
    chk("fat_log_valid", bus.log_valid, 1);
    chk("fat_log_sev", bus.log_sev, 0);
    chk("fat_log_src", bus.log_src, 4);
    chk("fat_drop", log_drop_count, 1);
    bus.ev_error = 8'hFF; @(negedge clk); idle();
    chk("stop_frozen", error_count, 2);
    chk("stop_log_hold", bus.log_src, 4);
    do_clr();

    // Log arbitration
    cfg_error_limit = '0; cfg_warn_en = 1'b1; cfg_info_en = 1'b1; bus.log_ready = 1'b1;
    bus.ev_warn = 8'h80; bus.ev_info = 8'h03; @(negedge clk); idle();
    chk("arb_valid", bus.log_valid, 1);
    chk("arb_sev", bus.log_sev, 2);
    chk("arb_src", bus.log_src, 7);
    chk("arb_drop", log_drop_count, 2);
    chk("arb_warn_cnt", warn_count, 1);
    @(negedge clk);
    chk("arb_drained", bus.log_valid, 0);
    bus.ev_debug = 8'hFF; @(negedge clk); idle();
    chk("dbg_masked_drop", log_drop_count, 2);
    chk("dbg_masked_valid", bus.log_valid, 0);
    cfg_warn_en = 1'b0; cfg_info_en = 1'b0;
    do_clr();

    // FIFO full and drop, then simultaneous pop+push on a full FIFO
    bus.log_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.ev_error = 8'(1 << i);
      @(negedge clk);
    end
    idle();
    chk("full_cnt", error_count, 6);
    chk("full_drop", log_drop_count, 2);
    chk("full_valid", bus.log_valid, 1);
    chk("full_head_sev", bus.log_sev, 1);
    chk("full_head_src", bus.log_src, 0);
    @(negedge clk);
    chk("full_hold", bus.log_src, 0);
    bus.log_ready = 1'b1; bus.ev_error = 8'h40; @(negedge clk); idle();
    chk("popush_drop", log_drop_count, 2);
    chk("popush_cnt", error_count, 7);
    chk("popush_head", bus.log_src, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_order", bus.log_src, exp_src[i]);
    end
    @(negedge clk);
    chk("drain_empty", bus.log_valid, 0);
    do_clr();

    // Saturation, then clr out of STOP
    for (int i = 0; i < 20; i++) begin
      bus.ev_warn = 8'h01;
      @(negedge clk);
    end
    idle();
    chk("sat_warn", warn_count, 15);
    chk("sat_warn_nodrop", log_drop_count, 0);
    bus.ev_error = 8'hFF; @(negedge clk);
    @(negedge clk); idle();
    chk("sat_err", error_count, 15);
    chk("sat_drop_acc", log_drop_count, 14);
    bus.ev_fatal = 8'h01; @(negedge clk); idle();
    chk("sat_stop", stop_req, 1);
    chk("sat_stop_cause", stop_cause, 1);
    do_clr();
    chk("sclr_warn", warn_count, 0);
    chk("sclr_err", error_count, 0);
    chk("sclr_stop", stop_req, 0);
    chk("sclr_cause", stop_cause, 0);
    chk("sclr_fatal", fatal_flag, 0);
    chk("sclr_first", first_err_valid, 0);
    chk("sclr_drop", log_drop_count, 0);
    chk("sclr_log", bus.log_valid, 0);
    bus.ev_warn = 8'h03; @(negedge clk); idle();
    chk("resume_warn", warn_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/msg_event_coordinator.md
# msg_event_coordinator

Synthesizable, multi-source successor to the simulation message coordinator. It collects per-source fatal, error, warn, info and debug event pulses from up to N_SRC blocks and keeps saturating severity counters and sticky flags. It enforces an error limit and a cycle timeout, raises a sticky stop request, and streams one selected event per cycle into a small log FIFO for a debug/CSR reader. It sits beside the top-level CSR block as the on-chip health monitor.

## Interface
- N_SRC, 8, number of event sources
- CNT_W, 16, width of severity/drop counters
- TO_W, 32, width of timeout timer
- LOG_DEPTH, 4, log FIFO entries (power of 2, ≥2)
- SRC_W, $clog2(N_SRC), source index width
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- clr  in  1  synchronous soft clear (counters, flags, timer, FIFO, state)
- cfg_error_limit  in  CNT_W  stop when error_count ≥ limit; 0 = no limit
- cfg_timeout  in  TO_W  stop after this many RUN cycles; 0 = disabled
- cfg_warn_en / cfg_info_en / cfg_debug_en  in  1 each  log-enable per severity (fatal, error always logged)
- ev_fatal, ev_error, ev_warn, ev_info, ev_debug  in  N_SRC each  single-cycle event pulses, bit i = source i
- error_count, warn_count  out  CNT_W  saturating counts
- log_drop_count  out  CNT_W  saturating count of log-eligible events not enqueued
- error_flag, fatal_flag, timeout_flag  out  1  sticky
- stop_req  out  1  sticky stop request
- stop_cause  out  2  0 none, 1 fatal, 2 error limit, 3 timeout
- first_err_valid  out  1; first_err_src  out  SRC_W  source of first error/fatal
- log_valid  out  1; log_ready  in  1; log_sev  out  3 (0 fatal,1 error,2 warn,3 info,4 debug); log_src  out  SRC_W

## Operation
- States: RUN, STOP. Reset/clr → RUN. RUN→STOP on any stop cause. STOP exits only via clr or rst_n.
- RUN counting: error_count += popcount(ev_error) + popcount(ev_fatal). warn_count += popcount(ev_warn) regardless of cfg_warn_en. Both saturate at all-ones.
- error_flag is set on any error/fatal event. fatal_flag is set on any fatal event or on timeout.
- first_err_src is captured on the first error/fatal event since reset/clr. Within that cycle, the lowest-index source among fatal|error bits wins. It is held thereafter.
- Error limit: when limit≠0 and the post-update count ≥ limit, enter STOP with cause 2.
- Timeout: timer counts RUN cycles from 0. When cfg_timeout≠0 and timer == cfg_timeout−1, enter STOP with cause 3, set timeout_flag and fatal_flag, and add 1 to error_count (saturating).
- Same-cycle causes: priority is fatal(1) > limit(2) > timeout(3). Only the first stop_cause is recorded.
- STOP: events are ignored, counters and timer frozen, flags held. The log FIFO keeps draining.
- Log selection, once per RUN cycle:
  - Eligible severities: fatal and error, plus warn/info/debug when their enable is set.
  - Pick the highest severity present, then the lowest source index within it.
  - log_drop_count += eligible_count − 1 when the FIFO accepts the pick, or eligible_count when the FIFO is full.
  - A simultaneous pop frees the slot: push when full and popping succeeds.
- FIFO: a pop occurs when log_valid && log_ready. Entries appear in push order.

## Timing
- All outputs are registered. Reset/clr value is 0 for every output, including log_valid and stop_cause.
- Event in cycle t → counters, flags, stop_req and stop_cause visible at t+1. A pushed entry has log_valid high at t+1 at the earliest.
- Timeout: with cfg_timeout = T, stop_req rises exactly T cycles after the first RUN cycle following reset/clr.
- clr has priority over same-cycle events; those events are discarded.
- rst_n low for any cycle clears everything at the next edge, regardless of state.
- log_sev/log_src are stable while log_valid && !log_ready.

## Test plan
- Error limit: limit=3; ev_error=8'h01 at t, then 8'h06 at t+1 → error_count 1 then 3, stop_req=1, stop_cause=2, first_err_src=0.
- Fatal beats limit: limit=1; same cycle ev_fatal=8'h10, ev_error=8'h02 → stop_cause=1, error_count=2, first_err_src=1, fatal_flag=1.
- Timeout: cfg_timeout=100, no events → stop_req rises 100 cycles after reset release; cause 3, error_count=1, timeout_flag=1.
- Log arbitration: ev_warn=8'h80, ev_info=8'h03, warn/info enabled, log_ready=1 → one entry (sev 2, src 7), log_drop_count=2.
- FIFO full/drop: LOG_DEPTH=4, log_ready=0, 6 single error pulses → 4 entries held, log_drop_count=2. Raising log_ready drains 4 entries in order.
- Saturation and clr: CNT_W=4, 20 warn pulses → warn_count=15. clr in STOP → all outputs 0, state RUN, counting resumes next cycle.
